// File: rtl/coef_loader.sv
// rtl/coef_loader.sv - receives NTAP coefficients plus a checksum and commits them to a FIR filter
//
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   start, abort            load request (IDLE only) / synchronous cancel
//   load_valid, load_data   upstream word stream (NTAP coefficients then one checksum)
//   load_ready              word accepted when load_valid && load_ready
//   h_write, h_idx, h_data  coefficient write port to the filter
//   busy, done, err         status: not idle / one-cycle completion pulse / checksum mismatch
module coef_loader #(
    parameter  int NTAP = 32,
    parameter  int DW   = 16,
    localparam int IW   = $clog2(NTAP)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic          abort,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          h_write,
    output logic [IW-1:0] h_idx,
    output logic [DW-1:0] h_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        CSUM   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] cnt, cnt_d;
    logic [DW-1:0] acc, acc_d;
    logic          err_d;
    logic          load_ready_d, h_write_d, busy_d, done_d;
    logic [IW-1:0] h_idx_d;
    logic [DW-1:0] h_data_d;
    logic          xfer;

    // Coefficient staging buffer; only ever read out after a complete,
    // checksum-verified transaction, so it needs no reset.
    logic [DW-1:0] buf_q [NTAP];

    assign xfer = load_valid && load_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        acc_d   = acc;
        err_d   = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RECV: begin
                if (xfer) begin
                    acc_d = acc + load_data;
                    cnt_d = cnt + IW'(1);
                    if (cnt == IW'(NTAP - 1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (load_data == acc) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                if (cnt == IW'(NTAP - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over start and over any transfer in the same cycle;
        // err keeps whatever value it had.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = acc;
            err_d   = err;
        end

        // Outputs are decoded from the next state so they come straight
        // out of flops and line up with the state they describe.
        load_ready_d = (state_d == RECV) || (state_d == CSUM);
        h_write_d    = (state_d == COMMIT);
        h_idx_d      = (state_d == COMMIT) ? cnt_d : '0;
        h_data_d     = (state_d == COMMIT) ? buf_q[cnt_d] : '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            err        <= 1'b0;
            load_ready <= 1'b0;
            h_write    <= 1'b0;
            h_idx      <= '0;
            h_data     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            acc        <= acc_d;
            err        <= err_d;
            load_ready <= load_ready_d;
            h_write    <= h_write_d;
            h_idx      <= h_idx_d;
            h_data     <= h_data_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RECV && xfer && !abort) begin
            buf_q[cnt] <= load_data;
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// tb/tb_coef_loader.sv - self-checking bench for coef_loader
module tb_coef_loader;

    localparam int NTAP = 32;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start, abort, load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready, h_write, busy, done, err;
    logic [4:0]    h_idx;
    logic [DW-1:0] h_data;

    int errors = 0;
    int checks = 0;

    coef_loader #(.NTAP(NTAP), .DW(DW)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .h_write(h_write), .h_idx(h_idx), .h_data(h_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: a queue of accepted words, a write
    // pointer while committing, and the status flags.
    bit            m_active, m_done, m_err;
    int            wpos = -1;
    logic [DW-1:0] q[$];
    logic [DW-1:0] tx[0:NTAP];
    logic [DW-1:0] wlog[$];
    int            ndone;

    function automatic bit exp_ready();
        return m_active && !m_done && wpos < 0 && q.size() <= NTAP;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        logic [DW-1:0] s;
        if (!n_reset) begin
            m_active = 0; m_done = 0; m_err = 0; wpos = -1; q.delete();
        end else if (abort) begin
            m_active = 0; m_done = 0; wpos = -1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_err = 0; q.delete();
            end
        end else if (m_done) begin
            m_done = 0; m_active = 0;
        end else if (wpos >= 0) begin
            if (wpos == NTAP - 1) begin
                wpos = -1; m_done = 1;
            end else begin
                wpos++;
            end
        end else if (load_valid) begin
            q.push_back(load_data);
            if (q.size() == NTAP + 1) begin
                s = '0;
                for (int k = 0; k < NTAP; k++) s = s + q[k];
                if (s == q[NTAP]) wpos = 0;
                else begin
                    m_err = 1; m_active = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] ed;
        ed = (wpos >= 0) ? q[wpos] : '0;
        chk("load_ready", {31'b0, load_ready}, {31'b0, exp_ready()});
        chk("h_write", {31'b0, h_write}, {31'b0, wpos >= 0});
        chk("h_idx", {27'b0, h_idx}, (wpos >= 0) ? wpos : 0);
        chk("h_data", {16'b0, h_data}, {16'b0, ed});
        chk("busy", {31'b0, busy}, {31'b0, m_active});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("err", {31'b0, err}, {31'b0, m_err});
        if (h_write) wlog.push_back(h_data);
        if (done) ndone++;
    end

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random gaps
    task automatic feed(input int mode, input bit extra_start, input int abort_after);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        while (i < NTAP + 1 && cyc < 400) begin
            load_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            load_data  = tx[i];
            start      = extra_start && (cyc == 7);
            abort      = (abort_after >= 0) && (i == abort_after);
            acc        = load_valid && exp_ready();
            @(posedge clk); #1;
            cyc++;
            if (abort) begin
                abort = 0; load_valid = 0; start = 0;
                return;
            end
            if (acc) i++;
        end
        load_valid = 0; start = 0;
        if (i < NTAP + 1) chk("feed_timeout", i, NTAP + 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_active) chk("idle_timeout", 1, 0);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < NTAP; k++) tx[k] = DW'(k + 1);
        tx[NTAP] = 16'h0210;
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_nwrites"}, wlog.size(), NTAP);
        for (int k = 0; k < NTAP && k < wlog.size(); k++)
            chk({tag, "_wdata"}, {16'b0, wlog[k]}, k + 1);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_err"}, {31'b0, err}, 0);
    endtask

    task automatic clear_log();
        wlog.delete();
        ndone = 0;
    endtask

    initial begin
        n_reset = 0; start = 0; abort = 0; load_valid = 0; load_data = '0;
        ndone = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {31'b0, load_ready}, 0);
        chk("rst_err", {31'b0, err}, 0);
        n_reset = 1;
        @(posedge clk); #1;

        // nominal ramp
        fill_ramp(); clear_log();
        pulse_start(); feed(0, 0, -1); wait_idle();
        @(posedge clk); #1;
        check_ramp("nominal");

        // bad checksum
        tx[NTAP] = 16'h0211; clear_log();
        pulse_start(); feed(0, 0, -1);
        chk("bad_err", {31'b0, err}, 1);
        chk("bad_busy", {31'b0, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_err_held", {31'b0, err}, 1);
        chk("bad_nwrites", wlog.size(), 0);
        pulse_start();
        chk("bad_err_clr", {31'b0, err}, 0);
        abort = 1; @(posedge clk); #1; abort = 0;

        // accumulator wrap
        for (int k = 0; k < NTAP; k++) tx[k] = 16'h0800;
        tx[NTAP] = 16'h0000; clear_log();
        pulse_start(); feed(0, 0, -1); wait_idle();
        @(posedge clk); #1;
        chk("wrap_nwrites", wlog.size(), NTAP);
        for (int k = 0; k < NTAP && k < wlog.size(); k++)
            chk("wrap_wdata", {16'b0, wlog[k]}, 32'h0800);
        chk("wrap_err", {31'b0, err}, 0);

        // stalls plus a stray start
        fill_ramp(); clear_log();
        pulse_start(); feed(1, 1, -1); wait_idle();
        @(posedge clk); #1;
        check_ramp("stall");

        // reset mid-commit
        fill_ramp(); clear_log();
        pulse_start(); feed(0, 0, -1);
        for (int n = 0; n < 40 && wpos != 10; n++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach_idx10", wpos, 10);
        #2 n_reset = 0;
        #1;
        chk("mrst_h_write", {31'b0, h_write}, 0);
        chk("mrst_h_idx", {27'b0, h_idx}, 0);
        chk("mrst_h_data", {16'b0, h_data}, 0);
        chk("mrst_busy", {31'b0, busy}, 0);
        chk("mrst_ready", {31'b0, load_ready}, 0);
        chk("mrst_done", {31'b0, done}, 0);
        chk("mrst_err", {31'b0, err}, 0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1;
        chk("mrst_ndone", ndone, 0);
        clear_log();
        pulse_start(); feed(0, 0, -1); wait_idle();
        @(posedge clk); #1;
        check_ramp("post_rst");

        // abort after 5 words
        clear_log();
        pulse_start(); feed(0, 0, 5);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_ready", {31'b0, load_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_nwrites", wlog.size(), 0);
        chk("abort_ndone", ndone, 0);
        pulse_start(); feed(0, 0, -1); wait_idle();
        @(posedge clk); #1;
        check_ramp("post_abort");

        // randomized transactions against the model
        for (int t = 0; t < 12; t++) begin
            logic [DW-1:0] s;
            s = '0;
            for (int k = 0; k < NTAP; k++) begin
                tx[k] = DW'($urandom);
                s = s + tx[k];
            end
            tx[NTAP] = ($urandom_range(0, 3) == 0) ? s + DW'($urandom_range(1, 255)) : s;
            pulse_start();
            feed(2, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32)) : -1);
            wait_idle();
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
